// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the instruction memory address
// and buffers returned words with their PCs in a circular prefetch queue for decode.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  input  logic [DATA_WIDTH-1:0] IMEM_RD,
  input  logic                  BRANCH_TAKEN,
  input  logic [ADDR_WIDTH-1:0] BRANCH_TARGET,
  output logic [DATA_WIDTH-1:0] INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_PC,
  output logic [ADDR_WIDTH-1:0] INSTR_PC_PLUS8,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY
);

  localparam int              PW      = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(QUEUE_DEPTH);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam logic [PW:0]     CNT_ONE = (PW+1)'(1);

  logic [ADDR_WIDTH-1:0] fpc_r, fpc_n_s;
  logic [PW-1:0]         rd_ptr_r, rd_ptr_n_s, wr_ptr_r, wr_ptr_n_s;
  logic [PW:0]           count_r, count_n_s;
  logic [DATA_WIDTH-1:0] instr_q_r [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q_r    [QUEUE_DEPTH];

  logic                  valid_s, pop_s, push_s, we_s;
  logic [ADDR_WIDTH-1:0] target_s;

  assign valid_s  = (count_r != {(PW+1){1'b0}});
  assign pop_s    = valid_s & INSTR_READY;
  // A full queue still accepts a new word when the head leaves in the same cycle.
  assign push_s   = (count_r < DEPTH_C) | pop_s;
  assign target_s = BRANCH_TARGET & ~ADDR_WIDTH'(3);

  // Next-state for PC, pointers and occupancy; a redirect flushes and suppresses the push.
  always_comb begin
    fpc_n_s    = fpc_r;
    rd_ptr_n_s = rd_ptr_r;
    wr_ptr_n_s = wr_ptr_r;
    count_n_s  = count_r;
    we_s       = 1'b0;
    if (BRANCH_TAKEN) begin
      fpc_n_s    = target_s;
      rd_ptr_n_s = {PW{1'b0}};
      wr_ptr_n_s = {PW{1'b0}};
      count_n_s  = {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        we_s       = ~RESET;
        wr_ptr_n_s = wr_ptr_r + PTR_ONE;
        fpc_n_s    = fpc_r + ADDR_WIDTH'(4);
      end else begin
        fpc_n_s    = fpc_r;
      end
      if (pop_s) begin
        rd_ptr_n_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_n_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_n_s = count_r + CNT_ONE;
        2'b01:   count_n_s = count_r - CNT_ONE;
        default: count_n_s = count_r;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fpc_r    <= RESET_PC;
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      fpc_r    <= fpc_n_s;
      rd_ptr_r <= rd_ptr_n_s;
      wr_ptr_r <= wr_ptr_n_s;
      count_r  <= count_n_s;
    end
  end

  // Entry storage is deliberately left unreset; occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (we_s) begin
      instr_q_r[wr_ptr_r] <= IMEM_RD;
      pc_q_r[wr_ptr_r]    <= fpc_r;
    end
  end

  assign IMEM_ADDR      = fpc_r;
  assign INSTR_VALID    = valid_s;
  assign INSTR          = valid_s ? instr_q_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
  assign INSTR_PC       = valid_s ? pc_q_r[rd_ptr_r]    : {ADDR_WIDTH{1'b0}};
  assign INSTR_PC_PLUS8 = valid_s ? (pc_q_r[rd_ptr_r] + ADDR_WIDTH'(8)) : {ADDR_WIDTH{1'b0}};

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, br, rdy, rst_w;
  logic [31:0] tgt;
  logic [31:0] imem_addr, imem_rd, instr, instr_pc, instr_pc8;
  logic        valid;
  logic [31:0] w_addr, w_rd, w_instr, w_pc, w_pc8;
  logic        w_valid;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'd0:   mem_f = 32'hE3A00001;
      32'd4:   mem_f = 32'hE3A01002;
      32'd8:   mem_f = 32'hE0802001;
      32'd12:  mem_f = 32'hEAFFFFFE;
      default: mem_f = (a * 32'h9E3779B1) ^ 32'hA5A5A5A5;
    endcase
  endfunction

  assign imem_rd = mem_f(imem_addr);
  assign w_rd    = mem_f(w_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RESET(rst), .IMEM_ADDR(imem_addr), .IMEM_RD(imem_rd),
    .BRANCH_TAKEN(br), .BRANCH_TARGET(tgt), .INSTR(instr), .INSTR_PC(instr_pc),
    .INSTR_PC_PLUS8(instr_pc8), .INSTR_VALID(valid), .INSTR_READY(rdy));

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .CLK(clk), .RESET(rst_w), .IMEM_ADDR(w_addr), .IMEM_RD(w_rd),
    .BRANCH_TAKEN(1'b0), .BRANCH_TARGET(32'h0000_0000), .INSTR(w_instr), .INSTR_PC(w_pc),
    .INSTR_PC_PLUS8(w_pc8), .INSTR_VALID(w_valid), .INSTR_READY(1'b1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: queue of {instr, pc}, fetch PC as plain number.
  logic [63:0] mq[$];
  logic [31:0] mfpc = 32'h0;

  task automatic model_step();
    if (rst) begin
      mq.delete();
      mfpc = 32'h0;
    end else if (br) begin
      mq.delete();
      mfpc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (mq.size() < 2) begin
        mq.push_back({mem_f(mfpc), mfpc});
        mfpc = mfpc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] h;
    h = (mq.size() > 0) ? mq[0] : 64'h0;
    check("imem_addr", imem_addr, mfpc);
    check("valid", {31'h0, valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    check("instr", instr, h[63:32]);
    check("instr_pc", instr_pc, h[31:0]);
    check("instr_pc8", instr_pc8, (mq.size() > 0) ? h[31:0] + 32'd8 : 32'h0);
  endtask

  task automatic cyc(input logic r, input logic b, input logic [31:0] t, input logic rd);
    @(negedge clk);
    rst = r; br = b; tgt = t; rdy = rd;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; br = 1'b0; tgt = 32'h0; rdy = 1'b0; rst_w = 1'b1;

    // Reset state, plus wrap-around instance run alongside.
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("rst_valid", {31'h0, valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("w_rst_addr", w_addr, 32'hFFFF_FFF8);
    check("w_rst_valid", {31'h0, w_valid}, 32'd0);
    rst_w = 1'b0;

    // Streaming with READY=1.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check("stream_valid", {31'h0, valid}, 32'd1);
      check("stream_pc", instr_pc, 32'(4 * k));
      check("stream_pc8", instr_pc8, 32'(4 * k + 8));
      check("stream_addr", imem_addr, 32'(4 * k + 4));
      if (k == 0) begin
        check("w_pc0", w_pc, 32'hFFFF_FFF8);
        check("w_addr0", w_addr, 32'hFFFF_FFFC);
      end else if (k == 1) begin
        check("w_pc1", w_pc, 32'hFFFF_FFFC);
        check("w_pc8_1", w_pc8, 32'h0000_0004);
        check("w_addr1", w_addr, 32'h0000_0000);
      end else if (k == 2) begin
        check("w_pc2", w_pc, 32'h0000_0000);
        check("w_pc8_2", w_pc8, 32'h0000_0008);
      end else begin
        check("w_pc3", w_pc, 32'h0000_0004);
      end
    end

    // Backpressure from reset.
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("bp_addr", imem_addr, 32'd8);
    check("bp_instr", instr, 32'hE3A00001);
    check("bp_pc", instr_pc, 32'd0);
    // Full plus pop: head 0 leaves, 8 enters, FPC 12.
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("fp_pc", instr_pc, 32'd4);
    check("fp_addr", imem_addr, 32'd12);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("fp_hold_pc", instr_pc, 32'd4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("drain_pc", instr_pc, 32'd8);

    // Branch flush with queue holding 8 and 12.
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("pre_br_pc", instr_pc, 32'd8);
    cyc(1'b0, 1'b1, 32'h41, 1'b0);
    check("br_valid", {31'h0, valid}, 32'd0);
    check("br_addr", imem_addr, 32'h40);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("br_pc", instr_pc, 32'h40);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("br_pc_next", instr_pc, 32'h44);

    // Reset with branch while full.
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h100, 1'b0);
    check("rb_valid", {31'h0, valid}, 32'd0);
    check("rb_addr", imem_addr, 32'h0);
    check("rb_instr", instr, 32'h0);
    check("rb_pc8", instr_pc8, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic r, b, d;
      logic [31:0] t;
      r = ($urandom_range(0, 49) == 0);
      b = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 2) != 0);
      t = $urandom_range(0, 255);
      cyc(r, b, t, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
